// File: rtl/cordic_result_fifo.sv
// -----------------------------------------------------------------------------
// cordic_result_fifo
//   Show-ahead result FIFO between the CORDIC core and the AHB bridge.
//   Pushes come from the CORDIC valid strobe. Pops come from the bridge, and the
//   head word is always presented combinationally on out_fifo. Pointers carry
//   one extra wrap bit so that full and empty can be told apart without a
//   separate occupancy register.
//
// Ports
//   HCLK          in   clock; all state updates on the rising edge
//   HRESETn       in   asynchronous active-low reset
//   wr_en         in   push request (one word per high cycle)
//   wr_data       in   word to push [DATA_W]
//   read_fifo_en  in   pop request
//   clr_err       in   synchronous clear of the sticky error flags
//   out_fifo      out  head entry, or zero when empty [DATA_W]
//   empty         out  FIFO holds zero entries
//   full          out  FIFO holds DEPTH entries
//   count         out  occupancy 0..DEPTH [ADDR_W+1]
//   overflow      out  sticky: a push was dropped because the FIFO was full
//   underflow     out  sticky: a pop was ignored because the FIFO was empty
// -----------------------------------------------------------------------------
module cordic_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              read_fifo_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] out_fifo,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  logic [ADDR_W-1:0] wr_idx, rd_idx;
  logic push_ok, pop_ok, push_drop, pop_drop;

  assign wr_idx = wr_ptr_q[ADDR_W-1:0];
  assign rd_idx = rd_ptr_q[ADDR_W-1:0];

  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_idx == rd_idx) && (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign pop_ok    = read_fifo_en && !empty;
  // A full FIFO still accepts a push when a pop frees the head slot in the same
  // cycle; the write lands in exactly the slot being read out.
  assign push_ok   = wr_en && (!full || read_fifo_en);
  assign push_drop = wr_en && full && !read_fifo_en;
  assign pop_drop  = read_fifo_en && empty;

  assign out_fifo  = empty ? '0 : mem_q[rd_idx];
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    // Clear first, then set, so a fresh error in the clear cycle survives.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (push_drop) overflow_d  = 1'b1;
    if (pop_drop)  underflow_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset. Clearing the pointers already makes
  // every stored word unreachable, and leaving the array out of reset lets it
  // map onto plain RAM.
  always_ff @(posedge HCLK) begin
    if (push_ok) mem_q[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_cordic_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_cordic_result_fifo
//   Directed stimulus with a scoreboard. The driver models occupancy and flags,
//   and queues each accepted word when the edge commits it. A monitor on the
//   falling edge checks the status outputs and the show-ahead head word, and
//   retires the head word whenever a pop is requested.
// -----------------------------------------------------------------------------
module tb_cordic_result_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              read_fifo_en;
  logic              clr_err;
  logic [DATA_W-1:0] out_fifo;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  cordic_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .HCLK         (clk),
    .HRESETn      (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .read_fifo_en (read_fifo_en),
    .clr_err      (clr_err),
    .out_fifo     (out_fifo),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: sb holds the words the FIFO should contain, head at [0].
  logic [DATA_W-1:0] sb[$];
  int   m_count = 0;
  logic m_ovf   = 1'b0;
  logic m_unf   = 1'b0;
  logic mon_en  = 1'b0;

  function automatic void check(string name, logic [DATA_W-1:0] act,
                                logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endfunction

  // Monitor: status outputs every cycle, head word every cycle, and the head
  // is retired from the scoreboard when a pop is requested.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [DATA_W-1:0] exp_head;
      exp_head = (sb.size() > 0) ? sb[0] : '0;
      check("count",     DATA_W'(count),     DATA_W'(m_count));
      check("empty",     DATA_W'(empty),     DATA_W'(m_count == 0));
      check("full",      DATA_W'(full),      DATA_W'(m_count == DEPTH));
      check("overflow",  DATA_W'(overflow),  DATA_W'(m_ovf));
      check("underflow", DATA_W'(underflow), DATA_W'(m_unf));
      check("out_fifo",  out_fifo,           exp_head);
      if (read_fifo_en && sb.size() > 0) void'(sb.pop_front());
    end
  end

  // One clock cycle of stimulus. Called just after a rising edge; returns just
  // after the next rising edge with the model updated for that edge.
  task automatic cyc(input logic wr, input logic [DATA_W-1:0] d,
                     input logic rd, input logic clr);
    int   pre;
    logic push_acc, pop_acc;
    pre      = m_count;
    pop_acc  = rd && (pre > 0);
    push_acc = wr && ((pre < DEPTH) || rd);
    wr_en        = wr;
    wr_data      = d;
    read_fifo_en = rd;
    clr_err      = clr;
    @(posedge clk);
    m_count = pre + (push_acc ? 1 : 0) - (pop_acc ? 1 : 0);
    if (push_acc) sb.push_back(d);
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (wr && pre == DEPTH && !rd) m_ovf = 1'b1;
    if (rd && pre == 0)            m_unf = 1'b1;
    #1;
    wr_en        = 1'b0;
    wr_data      = '0;
    read_fifo_en = 1'b0;
    clr_err      = 1'b0;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_empty"},     DATA_W'(empty),     32'd1);
    check({tag, "_full"},      DATA_W'(full),      32'd0);
    check({tag, "_count"},     DATA_W'(count),     32'd0);
    check({tag, "_out_fifo"},  out_fifo,           32'd0);
    check({tag, "_overflow"},  DATA_W'(overflow),  32'd0);
    check({tag, "_underflow"}, DATA_W'(underflow), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    wr_en        = 1'b0;
    wr_data      = '0;
    read_fifo_en = 1'b0;
    clr_err      = 1'b0;

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    idle(2);
    check_reset_state("idle");

    // Two pushes, two pops: head 0x11111111 then 0x22222222, count 2->1->0.
    push(32'h1111_1111);
    push(32'h2222_2222);
    check("two_push_count", DATA_W'(count), 32'd2);
    check("two_push_head",  out_fifo,       32'h1111_1111);
    pop();
    check("one_pop_count",  DATA_W'(count), 32'd1);
    check("one_pop_head",   out_fifo,       32'h2222_2222);
    pop();
    check("two_pop_empty",  DATA_W'(empty), 32'd1);
    idle(1);

    // Nine pushes into eight slots: ninth dropped, overflow set, 1..8 return.
    for (int i = 1; i <= 9; i++) begin
      push(DATA_W'(i));
      if (i == 8) check("full_after_8", DATA_W'(full), 32'd1);
    end
    check("overflow_after_9", DATA_W'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) pop();
    check("drained_empty", DATA_W'(empty), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("ovf_cleared", DATA_W'(overflow), 32'd0);

    // Pop while empty with a simultaneous push: underflow set, push accepted.
    cyc(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0);
    check("unf_set",      DATA_W'(underflow), 32'd1);
    check("unf_count",    DATA_W'(count),     32'd1);
    check("unf_head",     out_fifo,           32'hA5A5_A5A5);
    // Clear collides with a fresh empty pop the next cycle: set must win.
    pop();
    pop();
    cyc(1'b0, '0, 1'b1, 1'b1);
    check("set_beats_clr", DATA_W'(underflow), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("unf_cleared",  DATA_W'(underflow), 32'd0);

    // Mixed traffic that walks the pointers around their wrap point.
    for (int i = 0; i < 6; i++) begin
      push(32'h3000_0000 + DATA_W'(i));
      cyc(1'b1, 32'h4000_0000 + DATA_W'(i), 1'b1, 1'b0);
      pop();
    end
    pop();
    check("mixed_empty", DATA_W'(empty), 32'd1);

    // Fill to full, then push with simultaneous pop: count stays at DEPTH.
    for (int i = 0; i < DEPTH; i++) push(32'h5000_0000 + DATA_W'(i));
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("full_pushpop_count", DATA_W'(count),    32'd8);
    check("full_pushpop_ovf",   DATA_W'(overflow), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) pop();
    check("deadbeef_last", out_fifo, 32'hDEAD_BEEF);
    pop();
    check("deadbeef_empty", DATA_W'(empty), 32'd1);

    // Mid-cycle asynchronous reset with five entries stored and a flag set.
    for (int i = 0; i < 5; i++) push(32'h6000_0000 + DATA_W'(i));
    pop();
    pop();
    pop();
    pop();
    pop();
    pop();
    for (int i = 0; i < 5; i++) push(32'h7000_0000 + DATA_W'(i));
    check("pre_rst_count", DATA_W'(count),     32'd5);
    check("pre_rst_unf",   DATA_W'(underflow), 32'd1);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_state("async_rst");
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Normal operation resumes after reset.
    push(32'h8888_8888);
    check("post_rst_head", out_fifo, 32'h8888_8888);
    pop();
    idle(2);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
